// File: rtl/window_pkg.sv
// Shared constants and helpers for the streaming K x K window generator.
// Holds the default geometry, the windows-per-frame count and the
// geometry legality test used when the window buffer is elaborated.
package window_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_IMG_W  = 5;
  localparam int DEF_IMG_H  = 5;
  localparam int DEF_K      = 3;

  // Number of fully in-image K x K windows in one img_w x img_h frame.
  function automatic int windows_per_frame(input int img_w, input int img_h, input int k);
    return (img_h - k + 1) * (img_w - k + 1);
  endfunction

  // A window must fit inside the image and be at least 2 x 2.
  function automatic bit dims_ok(input int img_w, input int img_h, input int k);
    return (k >= 2) && (k <= img_w) && (k <= img_h);
  endfunction

  // Counter/address width for a 0..n-1 range, never narrower than 1 bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/window_buffer_line_ram.sv
// One image-row line memory: a single write port and an asynchronous read
// port sharing one address. A read in the same cycle as a write to that
// address returns the previously stored value.
module line_ram
  import window_pkg::*;
#(
  parameter int DEPTH  = DEF_IMG_W,
  parameter int DATA_W = DEF_DATA_W,
  localparam int AW    = cnt_w(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Row storage; contents are never reset and are overwritten before use.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/window_buffer.sv
// Streaming K x K sliding-window generator. Pixels arrive in raster order,
// K-1 line memories keep the previous rows, and a K x K register holds the
// current window. Every fully in-image window is emitted one cycle after
// the pixel that completes it.
module window_buffer
  import window_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int K      = DEF_K
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_enb,
  input  logic              i_sof,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data [K*K],
  output logic              o_last
);

  localparam int CW = cnt_w(IMG_W);
  localparam int RW = cnt_w(IMG_H);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_WIN0 = CW'(K - 1);
  localparam logic [RW-1:0] ROW_WIN0 = RW'(K - 1);

  if (!dims_ok(IMG_W, IMG_H, K)) begin : g_bad_dims
    $error("window_buffer: K must be >= 2 and no larger than IMG_W or IMG_H");
  end

  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;

  logic              w_acc_p0;
  logic [CW-1:0]     w_col_p0;
  logic [RW-1:0]     w_row_p0;
  logic              w_done_p0;
  logic              w_last_p0;
  logic [DATA_W-1:0] w_rd_p0     [K-1];
  logic [DATA_W-1:0] w_newcol_p0 [K];
  logic [DATA_W-1:0] w_win_nxt   [K][K];
  logic [DATA_W-1:0] r_win       [K][K];

  logic              r_vld_p1;
  logic              r_last_p1;
  logic [DATA_W-1:0] r_data_p1   [K*K];

  // ---- stage p0: accept pixel, resolve its position, read line memories ----
  // Reset wins over a pixel strobe in the same cycle.
  assign w_acc_p0 = i_enb & ~i_rst;

  // A start-of-frame pixel is always (0,0), whatever the counters say.
  assign w_col_p0 = i_sof ? '0 : r_col;
  assign w_row_p0 = i_sof ? '0 : r_row;

  assign w_done_p0 = w_acc_p0 && (w_row_p0 >= ROW_WIN0) && (w_col_p0 >= COL_WIN0);
  assign w_last_p0 = w_done_p0 && (w_row_p0 == ROW_LAST) && (w_col_p0 == COL_LAST);

  // Memory 0 holds the oldest row; memory K-2 holds the row just above.
  // Each memory hands its old value up the chain to the memory above it.
  for (genvar g = 0; g < K - 1; g++) begin : g_line
    logic [DATA_W-1:0] w_wdata;

    if (g == K - 2) begin : g_newest
      assign w_wdata = i_data;
    end else begin : g_older
      assign w_wdata = w_rd_p0[g+1];
    end

    line_ram #(
      .DEPTH  (IMG_W),
      .DATA_W (DATA_W)
    ) u_ram (
      .i_clk   (i_clk),
      .i_we    (w_acc_p0),
      .i_addr  (w_col_p0),
      .i_wdata (w_wdata),
      .o_rdata (w_rd_p0[g])
    );

    assign w_newcol_p0[g] = w_rd_p0[g];
  end

  assign w_newcol_p0[K-1] = i_data;

  // Next window: shift every row one column left and append the new column.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K - 1; j++) begin
        w_win_nxt[i][j] = r_win[i][j+1];
      end
      w_win_nxt[i][K-1] = w_newcol_p0[i];
    end
  end

  // Window shift register; data only, advanced on every accepted pixel.
  always_ff @(posedge i_clk) begin
    if (w_acc_p0) begin
      r_win <= w_win_nxt;
    end
  end

  // Raster position of the next pixel; wraps to (0,0) after the frame end.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_enb) begin
      if (w_col_p0 == COL_LAST) begin
        r_col <= '0;
        r_row <= (w_row_p0 == ROW_LAST) ? '0 : w_row_p0 + 1'b1;
      end else begin
        r_col <= w_col_p0 + 1'b1;
        r_row <= w_row_p0;
      end
    end
  end

  // ---- stage p1: registered window output ----
  // Window data is only reloaded on a completed window so it holds otherwise.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld_p1  <= 1'b0;
      r_last_p1 <= 1'b0;
      for (int n = 0; n < K * K; n++) begin
        r_data_p1[n] <= '0;
      end
    end else begin
      r_vld_p1  <= w_done_p0;
      r_last_p1 <= w_last_p0;
      if (w_done_p0) begin
        for (int i = 0; i < K; i++) begin
          for (int j = 0; j < K; j++) begin
            r_data_p1[i*K+j] <= w_win_nxt[i][j];
          end
        end
      end
    end
  end

  assign o_valid = r_vld_p1;
  assign o_last  = r_last_p1;
  assign o_data  = r_data_p1;

endmodule

// File: tb/tb_window_buffer.sv
// Bench for window_buffer: a 5x5/K=3 instance and an 8x6/K=5 instance,
// driven with directed frames and random gaps, checked cycle by cycle
// against an image-array reference model.
`timescale 1ns/1ps
module tb_window_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b0, enb_a = 1'b0, sof_a = 1'b0;
  logic [7:0]  din_a = '0;
  logic        vld_a, last_a;
  logic [7:0]  dout_a [9];

  logic        rst_b = 1'b0, enb_b = 1'b0, sof_b = 1'b0;
  logic [11:0] din_b = '0;
  logic        vld_b, last_b;
  logic [11:0] dout_b [25];

  window_buffer #(.DATA_W(8), .IMG_W(5), .IMG_H(5), .K(3)) u_a (
    .i_clk(clk), .i_rst(rst_a), .i_enb(enb_a), .i_sof(sof_a), .i_data(din_a),
    .o_valid(vld_a), .o_data(dout_a), .o_last(last_a)
  );

  window_buffer #(.DATA_W(12), .IMG_W(8), .IMG_H(6), .K(5)) u_b (
    .i_clk(clk), .i_rst(rst_b), .i_enb(enb_b), .i_sof(sof_b), .i_data(din_b),
    .o_valid(vld_b), .o_data(dout_b), .o_last(last_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: per instance geometry, next raster index, image copy
  // and the window currently expected on the outputs.
  int geo_w [2] = '{5, 8};
  int geo_h [2] = '{5, 6};
  int geo_k [2] = '{3, 5};
  int pos [2];
  int img [2][8][8];
  int exp_win [2][25];
  int win_cnt [2];

  typedef int win_t [25];
  win_t seen [$];
  bit   seen_last [$];

  task automatic step(input int d, input bit enb, input bit sof, input int data, input bit rst);
    int w, h, k, r, c, mask, ov, ol;
    bit ev, el;
    win_t ow;
    w = geo_w[d]; h = geo_h[d]; k = geo_k[d];
    mask = (d == 0) ? 255 : 4095;
    if (d == 0) begin
      rst_a = rst; enb_a = enb; sof_a = sof; din_a = 8'(data);
    end else begin
      rst_b = rst; enb_b = enb; sof_b = sof; din_b = 12'(data);
    end
    @(posedge clk);
    #1;
    rst_a = 1'b0; enb_a = 1'b0; sof_a = 1'b0;
    rst_b = 1'b0; enb_b = 1'b0; sof_b = 1'b0;
    ev = 1'b0; el = 1'b0;
    if (rst) begin
      pos[d] = 0;
      for (int i = 0; i < 25; i++) exp_win[d][i] = 0;
    end else if (enb) begin
      if (sof) pos[d] = 0;
      r = pos[d] / w;
      c = pos[d] % w;
      img[d][r][c] = data & mask;
      if (r >= k - 1 && c >= k - 1) begin
        ev = 1'b1;
        el = (r == h - 1) && (c == w - 1);
        for (int i = 0; i < k; i++)
          for (int j = 0; j < k; j++)
            exp_win[d][i*k+j] = img[d][r-k+1+i][c-k+1+j];
      end
      pos[d] = (pos[d] + 1) % (w * h);
    end
    ow = '{default: 0};
    if (d == 0) begin
      ov = int'(vld_a); ol = int'(last_a);
      for (int i = 0; i < 9; i++) ow[i] = int'(dout_a[i]);
    end else begin
      ov = int'(vld_b); ol = int'(last_b);
      for (int i = 0; i < 25; i++) ow[i] = int'(dout_b[i]);
    end
    check($sformatf("valid_u%0d", d), ov, int'(ev));
    check($sformatf("last_u%0d", d), ol, int'(el));
    for (int i = 0; i < k * k; i++)
      check($sformatf("data_u%0d[%0d]", d, i), ow[i], exp_win[d][i]);
    if (ov != 0) begin
      win_cnt[d]++;
      seen.push_back(ow);
      seen_last.push_back(ol != 0);
    end
  endtask

  task automatic send_frame(input int d, input int base, input int n, input bit gaps, input bit sof_first);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 3);
        for (int q = 0; q < g; q++) step(d, 1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)), 1'b0);
      end
      step(d, 1'b1, sof_first && (i == 0), base + i, 1'b0);
    end
  endtask

  task automatic clear_seen(input int d);
    seen.delete();
    seen_last.delete();
    win_cnt[d] = 0;
  endtask

  // Compares a captured window with the one defined by its top-left corner.
  task automatic check_win(input string tag, input int idx, input int d, input int base, input int top, input int left);
    int w, k;
    w = geo_w[d]; k = geo_k[d];
    if (idx >= seen.size()) begin
      check({tag, "_present"}, seen.size(), idx + 1);
    end else begin
      for (int i = 0; i < k; i++)
        for (int j = 0; j < k; j++)
          check($sformatf("%s[%0d]", tag, i*k+j), seen[idx][i*k+j], base + (top + i) * w + (left + j));
    end
  endtask

  task automatic check_last_at(input string tag, input int idx);
    check(tag, (idx < seen_last.size()) ? int'(seen_last[idx]) : 0, 1);
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b0; rst_b = 1'b0;

    // Reset state, including reset taking priority over a pixel strobe.
    step(0, 1'b1, 1'b1, 8'hA5, 1'b1);
    step(1, 1'b1, 1'b1, 12'h5A5, 1'b1);

    // Contiguous 5x5 frame.
    clear_seen(0);
    send_frame(0, 0, 25, 1'b0, 1'b0);
    check("t1_count", win_cnt[0], 9);
    check_win("t1_first", 0, 0, 0, 0, 0);
    check_win("t1_last_win", 8, 0, 0, 2, 2);
    check_last_at("t1_last_flag", 8);
    repeat (3) step(0, 1'b0, 1'b0, 0, 1'b0);

    // Same frame with idle gaps.
    clear_seen(0);
    send_frame(0, 0, 25, 1'b1, 1'b0);
    check("t2_count", win_cnt[0], 9);
    check_win("t2_first", 0, 0, 0, 0, 0);

    // Two back-to-back frames with no start-of-frame marker.
    clear_seen(0);
    send_frame(0, 0, 25, 1'b1, 1'b0);
    send_frame(0, 100, 25, 1'b0, 1'b0);
    check("t3_count", win_cnt[0], 18);
    check_win("t3_frame2_first", 9, 0, 100, 0, 0);

    // Restart with i_sof on the 16th pixel of a frame.
    clear_seen(0);
    send_frame(0, 0, 15, 1'b0, 1'b0);
    send_frame(0, 200, 25, 1'b1, 1'b1);
    check("t4_count", win_cnt[0], 12);
    check_win("t4_restart_first", 3, 0, 200, 0, 0);

    // Restart on the final pixel of a frame: its last window is dropped.
    clear_seen(0);
    send_frame(0, 0, 24, 1'b0, 1'b0);
    send_frame(0, 50, 25, 1'b0, 1'b1);
    check("t4b_count", win_cnt[0], 17);
    check_win("t4b_restart_first", 8, 0, 50, 0, 0);

    // Reset after pixel 17, then a clean frame.
    clear_seen(0);
    send_frame(0, 0, 18, 1'b0, 1'b0);
    step(0, 1'b1, 1'b0, 77, 1'b1);
    clear_seen(0);
    send_frame(0, 0, 25, 1'b0, 1'b0);
    check("t5_count", win_cnt[0], 9);
    check_win("t5_first", 0, 0, 0, 0, 0);

    // 8x6 image with a 5x5 window.
    clear_seen(1);
    send_frame(1, 0, 48, 1'b1, 1'b0);
    check("t6_count", win_cnt[1], 8);
    check_win("t6_first", 0, 1, 0, 0, 0);
    check("t6_last_topleft", (seen.size() > 7) ? seen[7][0] : -1, 11);
    check_last_at("t6_last_flag", 7);

    // Random data, gaps, occasional restarts and resets.
    for (int i = 0; i < 400; i++) begin
      int g;
      g = $urandom_range(0, 2);
      for (int q = 0; q < g; q++) step(0, 1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)), 1'b0);
      if ($urandom_range(0, 99) == 0)
        step(0, 1'($urandom_range(0, 1)), 1'b0, int'($urandom_range(0, 255)), 1'b1);
      else
        step(0, 1'b1, $urandom_range(0, 29) == 0, int'($urandom_range(0, 255)), 1'b0);
    end
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) step(1, 1'b0, 1'b0, 0, 1'b0);
      step(1, 1'b1, $urandom_range(0, 59) == 0, int'($urandom_range(0, 4095)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
